// File: rtl/face_frame_sequencer.sv
// rtl/face_frame_sequencer.sv - frame-level controller streaming pixel RAM into the face reader
module face_frame_sequencer #(
    parameter int WIDTH       = 256,
    parameter int DEPTH       = 256,
    parameter int COLOR_DEPTH = 8,
    parameter int ADDR_W      = 16,
    parameter int TIMEOUT     = 200000,
    parameter int TO_W        = 18
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   continuous,
    output logic                   mem_rd_en,
    output logic [ADDR_W-1:0]      mem_addr,
    input  logic [COLOR_DEPTH-1:0] mem_R,
    input  logic [COLOR_DEPTH-1:0] mem_G,
    input  logic [COLOR_DEPTH-1:0] mem_B,
    output logic                   fr_enable,
    output logic [COLOR_DEPTH-1:0] fr_R,
    output logic [COLOR_DEPTH-1:0] fr_G,
    output logic [COLOR_DEPTH-1:0] fr_B,
    input  logic                   fr_finish,
    input  logic [7:0]             fr_cx,
    input  logic [7:0]             fr_cy,
    input  logic                   fr_cdone,
    output logic                   busy,
    output logic                   result_valid,
    output logic [7:0]             result_x,
    output logic [7:0]             result_y,
    output logic [15:0]            frame_count,
    output logic                   timeout_err
);

    localparam int N_PIXELS = WIDTH * DEPTH;
    // One extra bit so the look-ahead address can reach N without wrapping.
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(N_PIXELS - 1);
    localparam logic [CNT_W-1:0] N_PIX    = CNT_W'(N_PIXELS);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_STREAM,
        S_WAIT_FIN_HI,
        S_WAIT_FIN_LO,
        S_WAIT_CDONE,
        S_DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] pix_cnt;   // index of the pixel presented to the reader this cycle
    logic [TO_W-1:0]  wd_cnt;
    logic [CNT_W-1:0] pix_ahead;

    // RAM read data lags the strobe by one cycle, so the address runs two pixels ahead of pix_cnt.
    assign pix_ahead = pix_cnt + CNT_W'(2);

    // Pixel path to the reader is open only while streaming.
    assign fr_R = (state == S_STREAM) ? mem_R : '0;
    assign fr_G = (state == S_STREAM) ? mem_G : '0;
    assign fr_B = (state == S_STREAM) ? mem_B : '0;

    // Frame FSM with registered RAM strobe, launch pulse, result latch and watchdog.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            pix_cnt      <= '0;
            wd_cnt       <= '0;
            mem_rd_en    <= 1'b0;
            mem_addr     <= '0;
            fr_enable    <= 1'b0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            result_x     <= '0;
            result_y     <= '0;
            frame_count  <= '0;
            timeout_err  <= 1'b0;
        end else begin
            fr_enable    <= 1'b0;
            result_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state       <= S_LAUNCH;
                        fr_enable   <= 1'b1;
                        mem_rd_en   <= 1'b1;
                        mem_addr    <= '0;
                        busy        <= 1'b1;
                        timeout_err <= 1'b0;
                    end
                end
                S_LAUNCH: begin
                    state     <= S_STREAM;
                    pix_cnt   <= '0;
                    mem_rd_en <= (N_PIXELS > 1);
                    mem_addr  <= (N_PIXELS > 1) ? ADDR_W'(1) : '0;
                end
                S_STREAM: begin
                    if (pix_cnt == LAST_PIX) begin
                        state     <= S_WAIT_FIN_HI;
                        wd_cnt    <= '0;
                        mem_rd_en <= 1'b0;
                        mem_addr  <= '0;
                    end else begin
                        pix_cnt   <= pix_cnt + CNT_W'(1);
                        mem_rd_en <= (pix_ahead < N_PIX);
                        mem_addr  <= (pix_ahead < N_PIX) ? pix_ahead[ADDR_W-1:0] : '0;
                    end
                end
                S_WAIT_FIN_HI: begin
                    if (fr_finish) begin
                        state  <= S_WAIT_FIN_LO;
                        wd_cnt <= '0;
                    end else if (wd_cnt == TO_LAST) begin
                        state       <= S_IDLE;
                        busy        <= 1'b0;
                        timeout_err <= 1'b1;
                        wd_cnt      <= '0;
                    end else begin
                        wd_cnt <= wd_cnt + TO_W'(1);
                    end
                end
                S_WAIT_FIN_LO: begin
                    if (!fr_finish) begin
                        state  <= S_WAIT_CDONE;
                        wd_cnt <= '0;
                    end else if (wd_cnt == TO_LAST) begin
                        state       <= S_IDLE;
                        busy        <= 1'b0;
                        timeout_err <= 1'b1;
                        wd_cnt      <= '0;
                    end else begin
                        wd_cnt <= wd_cnt + TO_W'(1);
                    end
                end
                S_WAIT_CDONE: begin
                    if (fr_cdone) begin
                        state        <= S_DONE;
                        result_x     <= fr_cx;
                        result_y     <= fr_cy;
                        result_valid <= 1'b1;
                        frame_count  <= frame_count + 16'd1;
                        wd_cnt       <= '0;
                    end else if (wd_cnt == TO_LAST) begin
                        state       <= S_IDLE;
                        busy        <= 1'b0;
                        timeout_err <= 1'b1;
                        wd_cnt      <= '0;
                    end else begin
                        wd_cnt <= wd_cnt + TO_W'(1);
                    end
                end
                S_DONE: begin
                    if (continuous) begin
                        state     <= S_LAUNCH;
                        fr_enable <= 1'b1;
                        mem_rd_en <= 1'b1;
                        mem_addr  <= '0;
                    end else begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_face_frame_sequencer.sv
// tb/tb_face_frame_sequencer.sv - scoreboard bench for face_frame_sequencer with a reader cycle model
module tb_face_frame_sequencer;

    localparam int W  = 4;
    localparam int D  = 4;
    localparam int N  = W * D;
    localparam int AW = 4;
    localparam int TO = 100;
    localparam int TW = 8;
    localparam int FIN_HOLD = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          continuous;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_R = '0, mem_G = '0, mem_B = '0;
    logic          fr_enable;
    logic [7:0]    fr_R, fr_G, fr_B;
    logic          fr_finish = 1'b0;
    logic [7:0]    fr_cx = '0, fr_cy = '0;
    logic          fr_cdone = 1'b0;
    logic          busy;
    logic          result_valid;
    logic [7:0]    result_x, result_y;
    logic [15:0]   frame_count;
    logic          timeout_err;

    face_frame_sequencer #(
        .WIDTH(W), .DEPTH(D), .COLOR_DEPTH(8), .ADDR_W(AW), .TIMEOUT(TO), .TO_W(TW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .continuous(continuous),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
        .mem_R(mem_R), .mem_G(mem_G), .mem_B(mem_B),
        .fr_enable(fr_enable), .fr_R(fr_R), .fr_G(fr_G), .fr_B(fr_B),
        .fr_finish(fr_finish), .fr_cx(fr_cx), .fr_cy(fr_cy), .fr_cdone(fr_cdone),
        .busy(busy), .result_valid(result_valid), .result_x(result_x), .result_y(result_y),
        .frame_count(frame_count), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Sync-read pixel RAM.
    logic [7:0] ram_r [N];
    logic [7:0] ram_g [N];
    logic [7:0] ram_b [N];
    always @(posedge clk) begin
        if (mem_rd_en) begin
            mem_R <= ram_r[mem_addr];
            mem_G <= ram_g[mem_addr];
            mem_B <= ram_b[mem_addr];
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Expected centroid of the reader model, derived straight from RAM contents.
    function automatic logic [15:0] expect_frame();
        int sr, sgb;
        logic [7:0] cx, cy;
        sr = 0;
        sgb = 0;
        for (int i = 0; i < N; i++) begin
            sr  += ram_r[i];
            sgb += ram_g[i] + ram_b[i];
        end
        cx = 8'(sr);
        cy = 8'(sgb);
        return {cx, cy};
    endfunction

    logic [15:0] exp_q[$];
    int exp_fc = 0;
    int en_count = 0;
    int e_cyc = -1000;
    int fin_fall_cyc = -1000;
    int k_m;

    typedef enum {R_IDLE, R_RECV, R_FIN, R_POST, R_DONE} rstate_t;
    rstate_t rs = R_IDLE;
    int sr_acc, sgb_acc, pix, hold, post_cnt;
    int cdone_delay = 3;
    bit hold_low = 1'b0;
    logic [15:0] popped;

    // Output monitor and scoreboard, then the reader cycle model (drives its outputs mid-cycle).
    always @(negedge clk) begin
        if (rst) begin
            e_cyc = -1000;
            rs = R_IDLE;
            fr_finish = 1'b0;
            fr_cdone = 1'b0;
            fr_cx = '0;
            fr_cy = '0;
        end else begin
            if (fr_enable) begin
                check("enable_reader_ready", (rs == R_IDLE || rs == R_DONE), 1);
                check("enable_gap_after_finish", (cyc > fin_fall_cyc), 1);
                en_count++;
                e_cyc = cyc;
            end
            k_m = cyc - e_cyc;
            check("mem_rd_en", mem_rd_en, (k_m >= 0 && k_m < N));
            if (k_m >= 0 && k_m < N)
                check("mem_addr", mem_addr, k_m);
            if (k_m >= 1 && k_m <= N) begin
                check("fr_R", fr_R, ram_r[k_m-1]);
                check("fr_G", fr_G, ram_g[k_m-1]);
                check("fr_B", fr_B, ram_b[k_m-1]);
            end else begin
                check("fr_rgb_idle_zero", {fr_R, fr_G, fr_B}, 0);
            end
            if (result_valid) begin
                check("result_expected", (exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    popped = exp_q.pop_front();
                    check("result_x", result_x, popped[15:8]);
                    check("result_y", result_y, popped[7:0]);
                end
                exp_fc++;
                check("frame_count_on_result", frame_count, exp_fc & 16'hFFFF);
            end

            case (rs)
                R_IDLE, R_DONE: begin
                    if (fr_enable) begin
                        fr_cdone = 1'b0;
                        sr_acc = 0;
                        sgb_acc = 0;
                        pix = 0;
                        rs = R_RECV;
                    end
                end
                R_RECV: begin
                    sr_acc += fr_R;
                    sgb_acc += fr_G + fr_B;
                    pix++;
                    if (pix == N) begin
                        if (hold_low) begin
                            rs = R_IDLE;
                        end else begin
                            fr_finish = 1'b1;
                            hold = FIN_HOLD;
                            rs = R_FIN;
                        end
                    end
                end
                R_FIN: begin
                    hold--;
                    if (hold == 0) begin
                        fr_finish = 1'b0;
                        fin_fall_cyc = cyc + 1;
                        if (cdone_delay == 0) begin
                            fr_cx = 8'(sr_acc);
                            fr_cy = 8'(sgb_acc);
                            fr_cdone = 1'b1;
                            rs = R_DONE;
                        end else begin
                            post_cnt = cdone_delay;
                            rs = R_POST;
                        end
                    end
                end
                R_POST: begin
                    post_cnt--;
                    if (post_cnt == 0) begin
                        fr_cx = 8'(sr_acc);
                        fr_cy = 8'(sgb_acc);
                        fr_cdone = 1'b1;
                        rs = R_DONE;
                    end
                end
                default: rs = R_IDLE;
            endcase
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 3000) begin
            tick();
            n++;
        end
        check(tag, busy, 0);
    endtask

    task automatic fill_random();
        for (int i = 0; i < N; i++) begin
            ram_r[i] = 8'($urandom);
            ram_g[i] = 8'($urandom);
            ram_b[i] = 8'($urandom);
        end
    endtask

    int base, t0, n;

    initial begin
        rst = 1'b1;
        start = 1'b0;
        continuous = 1'b0;
        fill_random();
        repeat (3) tick();
        check("rst_busy", busy, 0);
        check("rst_mem_rd_en", mem_rd_en, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_fr_enable", fr_enable, 0);
        check("rst_result_valid", result_valid, 0);
        check("rst_result_xy", {result_x, result_y}, 0);
        check("rst_frame_count", frame_count, 0);
        check("rst_timeout_err", timeout_err, 0);
        rst = 1'b0;

        // 1: start sampled at cycle 10, random RAM
        while (cyc < 9) tick();
        exp_q.push_back(expect_frame());
        start = 1'b1;
        tick();
        check("t1_launch_cycle", cyc, 10);
        check("t1_fr_enable_high", fr_enable, 1);
        start = 1'b0;
        tick();
        check("t1_fr_enable_single", fr_enable, 0);
        wait_idle("t1_complete");
        check("t1_frame_count", frame_count, 1);

        // 2: uniform RAM R=100 G=50
        for (int i = 0; i < N; i++) begin
            ram_r[i] = 8'd100;
            ram_g[i] = 8'd50;
            ram_b[i] = 8'd0;
        end
        exp_q.push_back(expect_frame());
        pulse_start();
        wait_idle("t2_complete");
        check("t2_frame_count", frame_count, 2);
        check("t2_result_x", result_x, 64);
        check("t2_result_y", result_y, 32);
        tick();
        check("t2_busy_low", busy, 0);

        // 3: three continuous frames, centroid ready on entry to the wait
        fill_random();
        cdone_delay = 0;
        continuous = 1'b1;
        base = en_count;
        repeat (3) exp_q.push_back(expect_frame());
        pulse_start();
        n = 0;
        while (en_count < base + 3 && n < 3000) begin
            tick();
            n++;
        end
        continuous = 1'b0;
        wait_idle("t3_complete");
        check("t3_launches", en_count - base, 3);
        check("t3_frame_count", frame_count, 5);
        cdone_delay = 3;

        // 5: start pulses during STREAM and WAIT_CDONE are ignored
        cdone_delay = 10;
        base = en_count;
        exp_q.push_back(expect_frame());
        pulse_start();
        repeat (4) tick();
        pulse_start();
        n = 0;
        while (rs != R_POST && n < 500) begin
            tick();
            n++;
        end
        repeat (2) tick();
        pulse_start();
        wait_idle("t5_complete");
        repeat (3) tick();
        check("t5_no_relaunch", busy, 0);
        check("t5_launches", en_count - base, 1);
        check("t5_frame_count", frame_count, 6);
        cdone_delay = 3;

        // 4: reader never raises fr_finish -> watchdog
        hold_low = 1'b1;
        pulse_start();
        t0 = cyc;
        n = 0;
        while (!timeout_err && n < 500) begin
            tick();
            n++;
        end
        check("t4_timeout_latency", cyc - t0, N + 1 + TO);
        check("t4_busy_low", busy, 0);
        check("t4_frame_count", frame_count, 6);
        hold_low = 1'b0;
        repeat (2) tick();
        check("t4_err_sticky", timeout_err, 1);
        exp_q.push_back(expect_frame());
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t4_err_cleared", timeout_err, 0);
        wait_idle("t4_recover");
        check("t4_frame_count_after", frame_count, 7);

        // 6: asynchronous reset mid-stream
        exp_q.push_back(expect_frame());
        pulse_start();
        t0 = cyc;
        while (cyc < t0 + 7) tick();
        #2 rst = 1'b1;
        #1;
        check("t6_busy", busy, 0);
        check("t6_mem_rd_en", mem_rd_en, 0);
        check("t6_fr_enable", fr_enable, 0);
        check("t6_fr_rgb", {fr_R, fr_G, fr_B}, 0);
        check("t6_frame_count", frame_count, 0);
        check("t6_result_xy", {result_x, result_y}, 0);
        exp_q.delete();
        exp_fc = 0;
        repeat (2) tick();
        rst = 1'b0;
        fill_random();
        exp_q.push_back(expect_frame());
        pulse_start();
        wait_idle("t6_clean_frame");
        check("t6_frame_count_after", frame_count, 1);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
